// File: rtl/rr_arb12_pkg.sv
// rr_arb12_pkg: shared sizes, state encodings and pointer helper for the 12-way arbiter
package rr_arb12_pkg;
    localparam int N   = 12;
    localparam int IDW = 4;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] id);
        return (id == IDW'(N - 1)) ? '0 : id + 1'b1;
    endfunction
endpackage

// File: rtl/rr_arb12_pick.sv
// rr_pick12: rotate-and-priority-encode search for the first request at or after ptr
module rr_pick12
    import rr_arb12_pkg::*;
(
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           hit,
    output logic [IDW-1:0] win
);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDW-1:0] off;
    logic [IDW:0]   sum;
    // bit k of rot is req[(ptr+k) mod N]; lowest set bit is the offset from ptr
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
        hit = |req;
        off = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) off = IDW'(i);
        sum = {1'b0, ptr} + {1'b0, off};
        win = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N)) : sum[IDW-1:0];
    end
endmodule

// File: rtl/rr_arb12.sv
// rr_arb12: 12-way round-robin arbiter with tenure limit and one dead cycle between owners
module rr_arb12
    import rr_arb12_pkg::*;
#(
    parameter int MAX_TEN = 8
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           idle
);
    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [3:0]     ten;
    logic           hit;
    logic [IDW-1:0] win;
    logic           own_req;
    logic           others;
    logic           release_own;

    rr_pick12 u_pick (
        .req(req),
        .ptr(ptr),
        .hit(hit),
        .win(win)
    );

    nor u_idle_nor (idle, req[0], req[1], req[2], req[3], req[4], req[5],
                    req[6], req[7], req[8], req[9], req[10], req[11]);

    // grant is one-hot on the owner, so masking req with it isolates owner vs. waiters
    always_comb begin
        own_req     = |(req & grant);
        others      = |(req & ~grant);
        release_own = !own_req || (ten == 4'(MAX_TEN) && others);
    end

    // arbitration FSM: IDLE picks, OWN holds until release or forced hand-off, GAP idles one cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            ptr       <= '0;
            ten       <= '0;
            grant     <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
        end else begin
            case (state)
                IDLE: if (hit) begin
                    state     <= OWN;
                    grant     <= N'(1) << win;
                    gnt_valid <= 1'b1;
                    gnt_id    <= win;
                    ten       <= 4'd1;
                end
                OWN: if (release_own) begin
                    state     <= GAP;
                    grant     <= '0;
                    gnt_valid <= 1'b0;
                    gnt_id    <= '0;
                    ptr       <= wrap_inc(gnt_id);
                    ten       <= '0;
                end else if (ten != 4'(MAX_TEN)) begin
                    ten <= ten + 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_arb12.sv
// tb_rr_arb12: directed and random stimulus against a cycle model via an expected-result queue
module tb_rr_arb12;
    typedef struct {
        logic [11:0] g;
        logic [3:0]  id;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic [11:0] req;
    logic [11:0] grant;
    logic        gnt_valid;
    logic [3:0]  gnt_id;
    logic        idle;

    exp_t sbq[$];
    int   vectors;
    int   miscompares;
    int   m_st;
    int   m_ptr;
    int   m_ten;
    int   m_own;

    rr_arb12 dut (
        .clk(clk),
        .rstn(rstn),
        .req(req),
        .grant(grant),
        .gnt_valid(gnt_valid),
        .gnt_id(gnt_id),
        .idle(idle)
    );

    // 20 ns clock period
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_ptr = 0;
        m_ten = 0;
        m_own = 0;
    endtask

    task automatic step(input logic [11:0] r);
        exp_t        e;
        logic [11:0] one;
        logic [11:0] others;
        bit          found;
        int          i;
        one = 12'h001;
        req = r;
        #10;
        chk("idle", 16'(idle), 16'(~|r));
        if (m_st == 0) begin
            found = 0;
            for (int k = 0; k < 12; k++) begin
                i = (m_ptr + k) % 12;
                if (!found && r[i]) begin
                    found = 1;
                    m_own = i;
                end
            end
            if (found) begin
                m_st  = 1;
                m_ten = 1;
            end
        end else if (m_st == 1) begin
            others = r & ~(one << m_own);
            if (!r[m_own] || (m_ten == 8 && others != 0)) begin
                m_st  = 2;
                m_ptr = (m_own + 1) % 12;
                m_ten = 0;
            end else if (m_ten < 8) begin
                m_ten = m_ten + 1;
            end
        end else begin
            m_st = 0;
        end
        e.g  = (m_st == 1) ? (one << m_own) : 12'h000;
        e.id = (m_st == 1) ? 4'(m_own) : 4'h0;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("grant", 16'(grant), 16'(e.g));
        chk("gnt_id", 16'(gnt_id), 16'(e.id));
        chk("gnt_valid", 16'(gnt_valid), 16'(|e.g));
        chk("onehot", 16'($onehot0(grant)), 16'd1);
    endtask

    initial begin
        logic [11:0] r;
        clk         = 0;
        rstn        = 0;
        req         = '0;
        vectors     = 0;
        miscompares = 0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_grant", 16'(grant), 16'h0000);
        chk("rst_id", 16'(gnt_id), 16'h0000);
        chk("rst_valid", 16'(gnt_valid), 16'h0000);
        rstn = 1;
        step(12'h000);
        step(12'h001);
        chk("first_grant", 16'(grant), 16'h0001);
        step(12'h000);
        step(12'h000);
        rstn = 0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1;
        for (int n = 0; n < 12; n++) step(12'h801);
        chk("tenure_handoff", 16'(grant), 16'h0800);
        step(12'h001);
        step(12'h001);
        step(12'h001);
        chk("wrap_grant", 16'(grant), 16'h0001);
        for (int n = 0; n < 40; n++) step(12'h020);
        chk("sole_hold", 16'(grant), 16'h0020);
        for (int n = 0; n < 5; n++) step(12'h008);
        chk("owner3", 16'(grant), 16'h0008);
        #4;
        rstn = 0;
        #1;
        chk("async_grant", 16'(grant), 16'h0000);
        chk("async_id", 16'(gnt_id), 16'h0000);
        chk("async_valid", 16'(gnt_valid), 16'h0000);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1;
        step(12'h008);
        chk("regrant", 16'(grant), 16'h0008);
        for (int n = 0; n < 3; n++) step(12'h000);
        r = 12'h000;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) r = 12'($urandom) & 12'($urandom);
            step(r);
        end
        for (int n = 0; n < 4; n++) step(12'h000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
